// File: rtl/peripheral_pwm_multi.sv
// Multi-channel PWM peripheral on the J1 I/O bus: shared prescaled timebase, per-channel
// duty/enable/polarity, double-buffered period and duty, sticky period-done interrupt.
module peripheral_pwm_multi #(
    parameter int unsigned NCH = 3,
    parameter int unsigned CW  = 10,
    parameter int unsigned PW  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [15:0]    d_in,
    input  logic           cs,
    input  logic [3:0]     addr,
    input  logic           rd,
    input  logic           wr,
    output logic [15:0]    d_out,
    output logic [NCH-1:0] pwm,
    output logic           irq
);

    logic           en_q, en_d;
    logic           irqen_q, irqen_d;
    logic [PW-1:0]  prescale_q, prescale_d;
    logic [PW-1:0]  pre_cnt_q, pre_cnt_d;
    logic [CW-1:0]  period_stg_q, period_stg_d;
    logic [CW-1:0]  period_sh_q, period_sh_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0] chen_q, chen_d;
    logic [NCH-1:0] pol_q, pol_d;
    logic [CW-1:0]  duty_stg_q [NCH];
    logic [CW-1:0]  duty_stg_d [NCH];
    logic [CW-1:0]  duty_sh_q [NCH];
    logic [CW-1:0]  duty_sh_d [NCH];
    logic           done_q, done_d;
    logic           irq_q, irq_d;
    logic [NCH-1:0] pwm_q, pwm_d;
    logic [15:0]    d_out_q, d_out_d;
    logic [15:0]    rdata;

    logic wr_en, rd_en, tick, wrap, status_rd;
    logic unused_d_in;

    assign unused_d_in = ^d_in;
    assign wr_en       = cs & wr;
    assign rd_en       = cs & rd;
    assign status_rd   = rd_en && (addr == 4'h3);
    assign tick        = (pre_cnt_q == prescale_q);
    assign wrap        = en_q & tick & (cnt_q == period_sh_q);

    // Register writes
    always_comb begin
        en_d         = en_q;
        irqen_d      = irqen_q;
        prescale_d   = prescale_q;
        period_stg_d = period_stg_q;
        chen_d       = chen_q;
        pol_d        = pol_q;
        duty_stg_d   = duty_stg_q;
        if (wr_en) begin
            case (addr)
                4'h0: begin
                    en_d    = d_in[0];
                    irqen_d = d_in[1];
                end
                4'h1:    prescale_d   = d_in[PW-1:0];
                4'h2:    period_stg_d = d_in[CW-1:0];
                4'h4:    chen_d       = d_in[NCH-1:0];
                4'h5:    pol_d        = d_in[NCH-1:0];
                default: ;
            endcase
            for (int unsigned i = 0; i < NCH; i++) begin
                if (addr == 4'(6 + i)) duty_stg_d[i] = d_in[CW-1:0];
            end
        end
    end

    // Timebase and shadow loading; shadows always take the pre-edge staged value
    always_comb begin
        pre_cnt_d   = pre_cnt_q;
        cnt_d       = cnt_q;
        period_sh_d = period_sh_q;
        duty_sh_d   = duty_sh_q;
        if (!en_q) begin
            pre_cnt_d   = '0;
            cnt_d       = '0;
            period_sh_d = period_stg_q;
            duty_sh_d   = duty_stg_q;
        end else begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
            if (tick) begin
                if (cnt_q == period_sh_q) begin
                    cnt_d       = '0;
                    period_sh_d = period_stg_q;
                    duty_sh_d   = duty_stg_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // Outputs, status and read data
    always_comb begin
        done_d = wrap | (done_q & ~status_rd);
        irq_d  = done_q & irqen_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            pwm_d[i] = (en_q & chen_q[i] & (cnt_q < duty_sh_q[i])) ^ pol_q[i];
        end
        rdata = '0;
        case (addr)
            4'h0:    rdata = {14'd0, irqen_q, en_q};
            4'h1:    rdata = 16'(prescale_q);
            4'h2:    rdata = 16'(period_stg_q);
            4'h3:    rdata = {15'd0, done_q};
            4'h4:    rdata = 16'(chen_q);
            4'h5:    rdata = 16'(pol_q);
            4'hF:    rdata = 16'(cnt_q);
            default: rdata = '0;
        endcase
        for (int unsigned i = 0; i < NCH; i++) begin
            if (addr == 4'(6 + i)) rdata = 16'(duty_stg_q[i]);
        end
        d_out_d = rd_en ? rdata : d_out_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q         <= 1'b0;
            irqen_q      <= 1'b0;
            prescale_q   <= '0;
            pre_cnt_q    <= '0;
            period_stg_q <= '0;
            period_sh_q  <= '0;
            cnt_q        <= '0;
            chen_q       <= '0;
            pol_q        <= '0;
            duty_stg_q   <= '{default: '0};
            duty_sh_q    <= '{default: '0};
            done_q       <= 1'b0;
            irq_q        <= 1'b0;
            pwm_q        <= '0;
            d_out_q      <= '0;
        end else begin
            en_q         <= en_d;
            irqen_q      <= irqen_d;
            prescale_q   <= prescale_d;
            pre_cnt_q    <= pre_cnt_d;
            period_stg_q <= period_stg_d;
            period_sh_q  <= period_sh_d;
            cnt_q        <= cnt_d;
            chen_q       <= chen_d;
            pol_q        <= pol_d;
            duty_stg_q   <= duty_stg_d;
            duty_sh_q    <= duty_sh_d;
            done_q       <= done_d;
            irq_q        <= irq_d;
            pwm_q        <= pwm_d;
            d_out_q      <= d_out_d;
        end
    end

    assign d_out = d_out_q;
    assign pwm   = pwm_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_peripheral_pwm_multi.sv
// Directed bench for peripheral_pwm_multi (NCH=3, CW=10, PW=8). All tasks begin and end just
// after a negedge; each bus access occupies exactly one posedge.
module tb_peripheral_pwm_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] d_in = '0;
    logic        cs = 1'b0;
    logic [3:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] d_out;
    logic [2:0]  pwm;
    logic        irq;

    int checks = 0;
    int passed = 0;

    peripheral_pwm_multi #(.NCH(3), .CW(10), .PW(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .d_in (d_in),
        .cs   (cs),
        .addr (addr),
        .rd   (rd),
        .wr   (wr),
        .d_out(d_out),
        .pwm  (pwm),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [15:0] v);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [15:0] v);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        v = d_out;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        step();
        step();
        rst_n = 1'b1;
        checks++;
        if (pwm !== 3'b000 || irq !== 1'b0 || d_out !== 16'h0) begin
            $display("FAIL reset_outputs: pwm=%b irq=%b d_out=%h, required 000 0 0000", pwm, irq, d_out);
        end else passed++;
        for (int a = 0; a < 16; a++) begin
            rd_reg(4'(a), v);
            checks++;
            if (v !== 16'h0) $display("FAIL reset_read[%0d]: got %h, required 0000", a, v);
            else passed++;
        end
        // RO and unmapped writes must be ignored; wide writes are truncated
        wr_reg(4'hF, 16'hFFFF);
        wr_reg(4'h3, 16'hFFFF);
        wr_reg(4'hE, 16'hFFFF);
        wr_reg(4'h2, 16'hFFFF);
        wr_reg(4'h4, 16'hFFFF);
        rd_reg(4'hF, v);
        checks++;
        if (v !== 16'h0) $display("FAIL ro_count_write: got %h, required 0000", v); else passed++;
        rd_reg(4'h3, v);
        checks++;
        if (v !== 16'h0) $display("FAIL ro_status_write: got %h, required 0000", v); else passed++;
        rd_reg(4'hE, v);
        checks++;
        if (v !== 16'h0) $display("FAIL unmapped_write: got %h, required 0000", v); else passed++;
        rd_reg(4'h2, v);
        checks++;
        if (v !== 16'h03FF) $display("FAIL period_width: got %h, required 03ff", v); else passed++;
        rd_reg(4'h4, v);
        checks++;
        if (v !== 16'h0007) $display("FAIL chen_width: got %h, required 0007", v); else passed++;
    endtask

    // Period 10, duty 3: high for the first 3 clocks after enabling
    task automatic test_pwm_basic();
        logic exp;
        wr_reg(4'h1, 16'd0);
        wr_reg(4'h2, 16'd9);
        wr_reg(4'h6, 16'd3);
        wr_reg(4'h4, 16'h1);
        wr_reg(4'h5, 16'h0);
        wr_reg(4'h0, 16'h1);
        for (int k = 1; k <= 20; k++) begin
            step();
            exp = ((k - 1) % 10) < 3;
            checks++;
            if (pwm !== {2'b00, exp}) $display("FAIL basic_pwm[%0d]: got %b, required %b", k, pwm, {2'b00, exp});
            else passed++;
        end
    endtask

    // Duty written mid-period takes effect only from the next boundary
    task automatic test_duty_update();
        logic [15:0] v;
        logic        exp;
        for (int m = 21; m <= 40; m++) begin
            if (m == 23) wr_reg(4'h6, 16'd7);
            else if (m == 24) begin
                rd_reg(4'h6, v);
                checks++;
                if (v !== 16'd7) $display("FAIL duty_readback: got %0d, required 7", v); else passed++;
            end else step();
            exp = (m <= 30) ? ((m - 21) < 3) : ((m - 31) < 7);
            checks++;
            if (pwm !== {2'b00, exp}) $display("FAIL duty_update[%0d]: got %b, required %b", m, pwm, {2'b00, exp});
            else passed++;
        end
    endtask

    // Prescale 3, period 4: 20-clock period; duty>period and duty=0 with inversion
    task automatic test_prescale_multi();
        logic [15:0] v;
        wr_reg(4'h0, 16'h0);
        wr_reg(4'h1, 16'd3);
        wr_reg(4'h2, 16'd4);
        wr_reg(4'h7, 16'd5);
        wr_reg(4'h8, 16'd0);
        wr_reg(4'h4, 16'h6);
        wr_reg(4'h5, 16'h4);
        rd_reg(4'h3, v);
        wr_reg(4'h0, 16'h1);
        checks++;
        if (pwm !== 3'b100) $display("FAIL idle_level: got %b, required 100", pwm); else passed++;
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if (pwm !== 3'b110) $display("FAIL multi_pwm[%0d]: got %b, required 110", k, pwm); else passed++;
        end
        rd_reg(4'hF, v);
        checks++;
        if (v !== 16'd4) $display("FAIL count_presc: got %0d, required 4", v); else passed++;
        step();
        step();
        rd_reg(4'h3, v);
        checks++;
        if (v !== 16'd0) $display("FAIL done_before_wrap: got %0d, required 0", v); else passed++;
        rd_reg(4'h3, v);
        checks++;
        if (v !== 16'd1) $display("FAIL done_after_20: got %0d, required 1", v); else passed++;
        rd_reg(4'h3, v);
        checks++;
        if (v !== 16'd0) $display("FAIL done_cleared: got %0d, required 0", v); else passed++;
        checks++;
        if (pwm !== 3'b110) $display("FAIL multi_pwm_end: got %b, required 110", pwm); else passed++;
    endtask

    // Period 3 clocks: wraps at E3, E6, E9, E12 after enabling at E0
    task automatic test_done_irq();
        logic [15:0] v;
        wr_reg(4'h0, 16'h0);
        wr_reg(4'h2, 16'd2);
        wr_reg(4'h1, 16'd0);
        rd_reg(4'h3, v);
        wr_reg(4'h0, 16'h3);
        step();
        step();
        step();
        checks++;
        if (irq !== 1'b0) $display("FAIL irq_lag: got %b, required 0", irq); else passed++;
        step();
        checks++;
        if (irq !== 1'b1) $display("FAIL irq_set: got %b, required 1", irq); else passed++;
        rd_reg(4'h3, v);
        checks++;
        if (v !== 16'd1) $display("FAIL status_read: got %0d, required 1", v); else passed++;
        checks++;
        if (irq !== 1'b1) $display("FAIL irq_hold: got %b, required 1", irq); else passed++;
        step();
        checks++;
        if (irq !== 1'b0) $display("FAIL irq_clear: got %b, required 0", irq); else passed++;
        step();
        checks++;
        if (irq !== 1'b1) $display("FAIL irq_reset: got %b, required 1", irq); else passed++;
        step();
        rd_reg(4'h3, v);
        checks++;
        if (v !== 16'd1) $display("FAIL status_at_wrap: got %0d, required 1", v); else passed++;
        rd_reg(4'h3, v);
        checks++;
        if (v !== 16'd1) $display("FAIL set_wins: got %0d, required 1", v); else passed++;
        rd_reg(4'h3, v);
        checks++;
        if (v !== 16'd0) $display("FAIL status_clr2: got %0d, required 0", v); else passed++;
    endtask

    task automatic test_disable_reset();
        logic [15:0] v;
        step();
        step();
        wr_reg(4'h0, 16'h0);
        checks++;
        if (pwm !== 3'b110) $display("FAIL disable_lag: got %b, required 110", pwm); else passed++;
        step();
        checks++;
        if (pwm !== 3'b100) $display("FAIL disable_idle: got %b, required 100", pwm); else passed++;
        rd_reg(4'hF, v);
        checks++;
        if (v !== 16'd0) $display("FAIL disable_count: got %0d, required 0", v); else passed++;
        wr_reg(4'h0, 16'h3);
        for (int k = 0; k < 5; k++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (pwm !== 3'b000 || irq !== 1'b0 || d_out !== 16'h0) begin
            $display("FAIL midrst_outputs: pwm=%b irq=%b d_out=%h, required 000 0 0000", pwm, irq, d_out);
        end else passed++;
        for (int a = 0; a < 16; a++) begin
            rd_reg(4'(a), v);
            checks++;
            if (v !== 16'h0) $display("FAIL midrst_read[%0d]: got %h, required 0000", a, v);
            else passed++;
        end
        step();
        checks++;
        if (pwm !== 3'b000) $display("FAIL midrst_pwm: got %b, required 000", pwm); else passed++;
    endtask

    initial begin
        test_reset();
        test_pwm_basic();
        test_duty_update();
        test_prescale_multi();
        test_done_irq();
        test_disable_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
